// File: rtl/draw_tile_layer_if.sv
// Pixel-stream bundle shared by the draw stages: counters, sync/blank timing and colour.
// The master drives the stream and the slave consumes it.
interface draw_tile_layer_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_tile_layer.sv
// Tiled-layer draw stage: addresses a tile ROM, absorbs its read latency and merges the tile
// colour over the upstream stream using a frame-latched mode, with colour key and blinking.
module draw_tile_layer #(
  parameter int          TILE_BITS    = 5,
  parameter int          ROM_LAT      = 1,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] KEY_COLOR    = 12'hF0F
) (
  input  logic                     pclk,
  input  logic                     rst_n,
  draw_tile_layer_if.slave         vin,
  draw_tile_layer_if.master        vout,
  input  logic [11:0]              rgb_pixel,
  input  logic                     layer_en,
  input  logic [1:0]               mode,
  output logic [2*TILE_BITS-1:0]   pixel_addr
);

  localparam int L = ROM_LAT + 1;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_KEY   = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_TILE  = 2'b11
  } mode_t;

  typedef struct packed {
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } timing_t;

  typedef struct packed {
    logic [11:0] rgb;
    logic        en;
  } colour_t;

  timing_t     t_q [L];
  colour_t     c_q [ROM_LAT];
  logic [11:0] rgb_q;
  logic [11:0] merge_rgb;
  logic        blank_s;

  mode_t       mode_act;
  logic        vsync_prev;
  logic        vblnk_prev;
  logic [7:0]  frm_cnt;
  logic        blink_ph;

  // The ROM is addressed straight from the incoming counters; tiles repeat every 2^TILE_BITS.
  assign pixel_addr = {vin.vcount[TILE_BITS-1:0], vin.hcount[TILE_BITS-1:0]};

  // NOTE: the delay lines are reset like any other flop so the first L outputs are defined zeros.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++)       t_q[i] <= '0;
      for (int i = 0; i < ROM_LAT; i++) c_q[i] <= '0;
    end else begin
      // NOTE: non-blocking, so every stage captures its neighbour's value from before the edge.
      t_q[0] <= {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk};
      c_q[0] <= {vin.rgb, layer_en};
      for (int i = 1; i < L; i++)       t_q[i] <= t_q[i-1];
      for (int i = 1; i < ROM_LAT; i++) c_q[i] <= c_q[i-1];
    end
  end

  // Mode is only taken at the start of vsync so a frame is never drawn with two modes.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_act   <= MODE_PASS;
      vsync_prev <= 1'b0;
      vblnk_prev <= 1'b0;
      frm_cnt    <= '0;
      blink_ph   <= 1'b0;
    end else begin
      vsync_prev <= vin.vsync;
      vblnk_prev <= vin.vblnk;
      if (vin.vsync && !vsync_prev) mode_act <= mode_t'(mode);
      if (vin.vblnk && !vblnk_prev) begin
        if (frm_cnt == 8'(BLINK_FRAMES - 1)) begin
          frm_cnt  <= '0;
          blink_ph <= ~blink_ph;
        end else begin
          frm_cnt  <= frm_cnt + 8'd1;
        end
      end
    end
  end

  // Stage ROM_LAT-1 holds the pixel whose tile data is arriving on rgb_pixel this cycle.
  assign blank_s = t_q[ROM_LAT-1].hblnk | t_q[ROM_LAT-1].vblnk;

  always_comb begin
    // NOTE: default first, so no path leaves merge_rgb unassigned and no latch is inferred.
    merge_rgb = rgb_pixel;
    if (blank_s)
      merge_rgb = '0;
    else if (!c_q[ROM_LAT-1].en || mode_act == MODE_PASS)
      merge_rgb = c_q[ROM_LAT-1].rgb;
    else if (mode_act == MODE_TILE)
      merge_rgb = rgb_pixel;
    else if (rgb_pixel == KEY_COLOR)
      merge_rgb = c_q[ROM_LAT-1].rgb;
    else if (mode_act == MODE_BLINK && blink_ph)
      merge_rgb = c_q[ROM_LAT-1].rgb;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) rgb_q <= '0;
    else        rgb_q <= merge_rgb;
  end

  assign vout.hcount = t_q[L-1].hcount;
  assign vout.vcount = t_q[L-1].vcount;
  assign vout.hsync  = t_q[L-1].hsync;
  assign vout.vsync  = t_q[L-1].vsync;
  assign vout.hblnk  = t_q[L-1].hblnk;
  assign vout.vblnk  = t_q[L-1].vblnk;
  assign vout.rgb    = rgb_q;

endmodule

// File: tb/tb_draw_tile_layer.sv
// Bench for draw_tile_layer: two instances (ROM_LAT=1/BLINK_FRAMES=2 and ROM_LAT=3/BLINK_FRAMES=1)
// compared every cycle against a history-based model, plus directed literal expectations.
module tb_draw_tile_layer;
  localparam int H = 4096;

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic        en;
    logic [1:0]  mode;
  } vec_t;

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } out_t;

  logic pclk  = 1'b0;
  logic rst_n = 1'b0;
  vec_t cur   = '0;
  int   checks = 0;
  int   errors = 0;

  always #5 pclk = ~pclk;

  draw_tile_layer_if vin();
  draw_tile_layer_if vout_a();
  draw_tile_layer_if vout_b();

  assign vin.hcount = cur.h;
  assign vin.vcount = cur.v;
  assign vin.hsync  = cur.hs;
  assign vin.vsync  = cur.vs;
  assign vin.hblnk  = cur.hb;
  assign vin.vblnk  = cur.vb;
  assign vin.rgb    = cur.rgb;

  // Tile ROM and its read-latency pipes, one per instance.
  logic [11:0] rom [1024];
  logic [9:0]  paddr_a, paddr_b;
  logic [9:0]  addr_a = '0;
  logic [9:0]  addr_b [3] = '{default: '0};
  logic [11:0] rgbpix_a, rgbpix_b;

  always @(posedge pclk) begin
    addr_a    <= paddr_a;
    addr_b[0] <= paddr_b;
    addr_b[1] <= addr_b[0];
    addr_b[2] <= addr_b[1];
  end
  assign rgbpix_a = rom[addr_a];
  assign rgbpix_b = rom[addr_b[2]];

  draw_tile_layer #(.TILE_BITS(5), .ROM_LAT(1), .BLINK_FRAMES(2), .KEY_COLOR(12'hF0F)) u_a (
    .pclk(pclk), .rst_n(rst_n), .vin(vin), .vout(vout_a), .rgb_pixel(rgbpix_a),
    .layer_en(cur.en), .mode(cur.mode), .pixel_addr(paddr_a));

  draw_tile_layer #(.TILE_BITS(5), .ROM_LAT(3), .BLINK_FRAMES(1), .KEY_COLOR(12'hF0F)) u_b (
    .pclk(pclk), .rst_n(rst_n), .vin(vin), .vout(vout_b), .rgb_pixel(rgbpix_b),
    .layer_en(cur.en), .mode(cur.mode), .pixel_addr(paddr_b));

  // Model: record every input cycle, the latched mode and the number of vblank starts since reset.
  int         cyc = 0;
  int         last_rst = 0;
  logic [1:0] m_mode = 2'b00;
  logic       vs_prev = 1'b0;
  logic       vb_prev = 1'b0;
  int         edges = 0;
  vec_t       hist_in   [H];
  logic [1:0] mode_hist [H];
  int         edge_hist [H];

  always @(posedge pclk) begin
    cyc = cyc + 1;
    hist_in[cyc % H] = cur;
    if (!rst_n) begin
      last_rst = cyc;
      m_mode   = 2'b00;
      vs_prev  = 1'b0;
      vb_prev  = 1'b0;
      edges    = 0;
    end else begin
      if (cur.vs && !vs_prev) m_mode = cur.mode;
      if (cur.vb && !vb_prev) edges = edges + 1;
      vs_prev = cur.vs;
      vb_prev = cur.vb;
    end
    mode_hist[cyc % H] = m_mode;
    edge_hist[cyc % H] = edges;
  end

  // Output after edge k carries the pixel presented at edge k-ROM_LAT, merged in the cycle before k.
  function automatic out_t exp_out(input int rom_lat, input int bf);
    int          k;
    int          src;
    vec_t        v;
    out_t        o;
    logic [11:0] px;
    logic [1:0]  md;
    logic        bl;
    k   = cyc;
    src = k - rom_lat;
    o   = '0;
    if (!rst_n || src <= last_rst) return o;
    v  = hist_in[src % H];
    px = rom[{v.v[4:0], v.h[4:0]}];
    md = mode_hist[(k-1) % H];
    bl = ((edge_hist[(k-1) % H] / bf) % 2) == 1;
    o.h = v.h; o.v = v.v; o.hs = v.hs; o.vs = v.vs; o.hb = v.hb; o.vb = v.vb;
    if (v.hb || v.vb)                 o.rgb = 12'h000;
    else if (!v.en || md == 2'b00)    o.rgb = v.rgb;
    else if (md == 2'b11)             o.rgb = px;
    else if (px == 12'hF0F)           o.rgb = v.rgb;
    else if (md == 2'b10 && bl)       o.rgb = v.rgb;
    else                              o.rgb = px;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    out_t       ea, eb, aa, ab;
    logic [9:0] ep;
    ea = exp_out(1, 2);
    eb = exp_out(3, 1);
    aa = {vout_a.hcount, vout_a.vcount, vout_a.hsync, vout_a.vsync, vout_a.hblnk, vout_a.vblnk, vout_a.rgb};
    ab = {vout_b.hcount, vout_b.vcount, vout_b.hsync, vout_b.vsync, vout_b.hblnk, vout_b.vblnk, vout_b.rgb};
    ep = {cur.v[4:0], cur.h[4:0]};
    check("a_stream", 64'(aa), 64'(ea));
    check("b_stream", 64'(ab), 64'(eb));
    check("a_addr", 64'(paddr_a), 64'(ep));
    check("b_addr", 64'(paddr_b), 64'(ep));
  endtask

  // One pixel period: compare on the falling edge, then return 2 ns after the rising edge.
  task automatic tick();
    @(negedge pclk);
    compare_all();
    @(posedge pclk);
    #2;
  endtask

  // Small synthetic frame: 16 pixels x 6 lines, hblank from pixel 12, vblank lines 4-5, vsync line 5.
  task automatic run_frame(input logic [1:0] md0, input logic [1:0] md1, input int sw_line);
    for (int v = 0; v < 6; v++) begin
      for (int h = 0; h < 16; h++) begin
        cur.h    = 12'(h);
        cur.v    = 12'(v);
        cur.hb   = (h >= 12);
        cur.vb   = (v >= 4);
        cur.hs   = (h >= 13 && h < 15);
        cur.vs   = (v == 5);
        cur.rgb  = 12'(12'h100 + h * 16 + v * 3);
        cur.en   = (h != 3);
        cur.mode = (v >= sw_line) ? md1 : md0;
        tick();
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = (i % 5 == 2) ? 12'hF0F : 12'(i * 37 + 11);
    rom[197] = 12'h123;
    rom[198] = 12'hFFF;
    rom[199] = 12'hF0F;
    rom[200] = 12'h00F;

    repeat (3) tick();
    check("reset_rgb_a", 64'(vout_a.rgb), 64'h0);
    check("reset_hcount_b", 64'(vout_b.hcount), 64'h0);
    rst_n = 1'b1;
    tick();
    tick();

    // Latch tile-only mode on a vsync rising edge, mode presented in the same cycle.
    cur.vs = 1'b1; cur.mode = 2'b11; tick();
    cur.vs = 1'b0; tick();

    cur.h = 12'd37; cur.v = 12'd70; cur.en = 1'b1; cur.rgb = 12'h555; cur.hb = 1'b0; cur.vb = 1'b0;
    #1 check("pixel_addr_37_70", 64'(paddr_a), 64'(10'b00110_00101));
    tick();
    cur.h = 12'd38; cur.hb = 1'b1; tick();
    check("tile_rgb", 64'(vout_a.rgb), 64'h123);
    check("tile_hcount", 64'(vout_a.hcount), 64'd37);
    cur.h = 12'd39; cur.hb = 1'b0; tick();
    check("blank_rgb", 64'(vout_a.rgb), 64'h0);
    check("blank_hblnk", 64'(vout_a.hblnk), 64'h1);

    // Keyed overlay.
    cur.vs = 1'b1; cur.mode = 2'b01; tick();
    cur.vs = 1'b0; cur.h = 12'd39; cur.rgb = 12'h0A0; tick();
    cur.h = 12'd40; tick();
    check("key_transparent", 64'(vout_a.rgb), 64'h0A0);
    cur.h = 12'd41; tick();
    check("key_opaque", 64'(vout_a.rgb), 64'h00F);

    // Mode input changes without a vsync edge must not take effect.
    cur.mode = 2'b11; cur.h = 12'd39; tick();
    cur.h = 12'd41; tick();
    check("midframe_mode_held", 64'(vout_a.rgb), 64'h0A0);
    cur.vs = 1'b1; tick();
    cur.vs = 1'b0; cur.h = 12'd39; tick();
    cur.h = 12'd41; tick();
    check("relatched_tile", 64'(vout_a.rgb), 64'hF0F);

    // Streaming frames: pass, mid-frame switch, tile, key, blinking, pass.
    run_frame(2'b00, 2'b00, 6);
    run_frame(2'b00, 2'b11, 2);
    run_frame(2'b11, 2'b11, 0);
    run_frame(2'b01, 2'b01, 0);
    repeat (6) run_frame(2'b10, 2'b10, 0);
    run_frame(2'b00, 2'b00, 0);

    // Asynchronous reset in the middle of a visible line.
    cur.h = 12'd5; cur.v = 12'd1; cur.hs = 1'b0; cur.vs = 1'b0; cur.hb = 1'b0; cur.vb = 1'b0;
    cur.en = 1'b1; cur.rgb = 12'h3C3; cur.mode = 2'b00;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_rgb_a", 64'(vout_a.rgb), 64'h0);
    check("async_rst_rgb_b", 64'(vout_b.rgb), 64'h0);
    check("async_rst_hcount_b", 64'(vout_b.hcount), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    cur.mode = 2'b11; cur.h = 12'd41; cur.v = 12'd70; tick();
    cur.h = 12'd42; tick();
    tick();
    tick();
    check("post_rst_pass_rgb_b", 64'(vout_b.rgb), 64'h3C3);
    check("post_rst_hcount_b", 64'(vout_b.hcount), 64'd41);

    run_frame(2'b11, 2'b11, 0);
    run_frame(2'b11, 2'b11, 0);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/draw_tile_layer.md
# draw_tile_layer

Parametrised VGA pixel-pipeline stage that overlays a tiled sprite/background layer onto the incoming RGB stream, replacing the fixed two-stage background drawer. It computes a tile-ROM address from the current counters and absorbs a configurable ROM read latency. It delays all timing signals by the same amount. It merges the tile colour with the upstream colour according to a frame-synchronised mode, including colour-key transparency and frame-counted blinking. It sits between the timing generator (or a previous draw stage) and the next draw stage or VGA output.

## Interface
- TILE_BITS, 5, log2 of tile edge in pixels (5 = 32x32 tile); pixel_addr width is 2*TILE_BITS
- ROM_LAT, 1, cycles from pixel_addr to matching rgb_pixel (legal 1..4)
- BLINK_FRAMES, 30, frames per blink half-period (legal 1..255)
- KEY_COLOR, 12'hF0F, tile colour treated as transparent in overlay modes
- pclk  in  1  pixel clock; everything is clocked on its rising edge
- rst_n  in  1  reset; asynchronous and active-low
- hcount_in, vcount_in  in  12 each  pixel counters
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing signals
- rgb_in  in  12  upstream colour (background)
- rgb_pixel  in  12  tile-ROM data, valid ROM_LAT cycles after its address
- layer_en  in  1  per-pixel enable, aligned with hcount_in
- mode  in  2  00 pass rgb_in, 01 keyed overlay, 10 keyed overlay blinking, 11 tile only (no key)
- hcount_out, vcount_out  out  12 each  delayed counters
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing
- rgb_out  out  12  merged colour
- pixel_addr  out  2*TILE_BITS  {vcount_in[TILE_BITS-1:0], hcount_in[TILE_BITS-1:0]}, combinational

## Operation
- Total stage latency L = ROM_LAT+1. hcount, vcount, the sync and blank signals, rgb_in and layer_en pass through an L-deep shift register; the Lth stage drives the outputs.
- pixel_addr is combinational from the inputs and unregistered, so the ROM sees the address in cycle t. rgb_pixel is consumed at t+ROM_LAT together with pipeline stage ROM_LAT. The merge result is registered into rgb_out at t+L.
- Mode latch: mode_act (reset 00) loads mode on the rising edge of vsync_in (vsync_in=1 with its previous registered value 0). Mode changes mid-frame never affect the current frame.
- Frame counter: 8-bit frm_cnt and blink_ph (reset 0, 0). They advance on each rising edge of vblnk_in. When frm_cnt==BLINK_FRAMES-1, frm_cnt wraps to 0 and blink_ph toggles; otherwise frm_cnt increments. Counting runs in every mode.
- Merge, with the aligned stage values: if hblnk or vblnk, output 0. Else if !layer_en or mode_act==00, output rgb_in. Else if mode_act==11, output rgb_pixel. Else if rgb_pixel==KEY_COLOR, output rgb_in. Else if mode_act==10 and blink_ph==1, output rgb_in. Else output rgb_pixel.
- No arithmetic on colour; all comparisons are full 12-bit equality.

## Timing
- Reset (rst_n=0, asynchronous): all outputs 0, all pipeline stages 0, mode_act=00, frm_cnt=0, blink_ph=0, vsync edge detector = 0. pixel_addr still follows the inputs.
- First valid output L cycles after inputs are applied following reset release. Outputs during the first L cycles are the reset zeros.
- Reset mid-frame clears the pipeline immediately. The first vsync edge after release relatches mode.
- Simultaneous vsync rising edge and mode change: the value of mode in that cycle is latched.
- BLINK_FRAMES=1: blink_ph toggles every frame.
- pixel_addr wraps every 2^TILE_BITS pixels in both axes (tiling); no saturation.

## Test plan
- Defaults. Apply hcount=37, vcount=70, pixel_addr check -> 10'b00110_00101. ROM model returns 12'h123 one cycle later; mode_act=11, layer_en=1 -> rgb_out=12'h123 exactly 2 cycles after input, with hcount_out=37.
- Blanking: hblnk_in=1, mode 11, rgb_pixel=12'hFFF -> rgb_out=0 at t+2, hblnk_out=1.
- Key: mode 01, rgb_pixel=12'hF0F, rgb_in=12'h0A0 -> rgb_out=12'h0A0. rgb_pixel=12'h00F -> 12'h00F.
- Mode latch: change mode 00->11 mid-frame -> output stays rgb_in until after the next vsync_in rising edge, then shows rgb_pixel.
- Blink: BLINK_FRAMES=2, mode 10, non-key tile. Frames 0-1 show tile, frames 2-3 show rgb_in, frame 4 shows tile.
- ROM_LAT=3. Outputs and timing are delayed 4 cycles. Async rst_n pulse mid-line zeroes all outputs within the same cycle and clears mode_act to 00.
